// File: rtl/uart_tx_8_if.sv
// Byte handshake between a data source (master) and the UART transmitter (slave).
interface uart_tx_8_if;
   logic [7:0] d_in;
   logic       d_valid;
   logic       d_ready;

   modport master (output d_in, output d_valid, input d_ready);
   modport slave  (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/uart_tx_8.sv
// 8N1 UART transmitter with valid/ready byte intake and registered serial output.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_8 #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   uart_tx_8_if.slave  dif,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_done;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   assign bit_done    = (cnt_q == CntMax);
   assign dif.d_ready = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign tx          = tx_q;

   // tx_d is the line level for the state being entered, so tx is glitch-free.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (state_q != StIdle) begin
         cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
      end
      unique case (state_q)
         StIdle: begin
            if (dif.d_valid) begin
               state_d = StStart;
               shift_d = dif.d_in;
               tx_d    = 1'b0;
               cnt_d   = '0;
               idx_d   = '0;
`ifdef UART_TX_PARITY_EN
               parity_d = ^dif.d_in;
`endif
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d = StData;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (bit_done) begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
                  tx_d    = parity_q;
`else
                  state_d = StStop;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_done) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
`endif
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_8.sv
// Randomized self-checking bench for uart_tx_8 against a frame-level reference model.
module tb_uart_tx_8;

   localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBits = 11;
`else
   localparam int NBits = 10;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx, busy;
   int   n_cmp = 0;
   int   n_fail = 0;

   uart_tx_8_if dif ();

   uart_tx_8 #(.CLKS_PER_BIT(Cpb)) dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif.slave),
      .tx    (tx),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame as a list of line levels, one per bit period.
   function automatic logic [10:0] build_frame(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   // Model: el = cycles since acceptance (-1 when idle).
   int          el = -1;
   logic [10:0] frame = '1;

   always begin
      @(posedge clk);
      if (reset) begin
         el = -1;
      end else if (el < 0) begin
         if (dif.d_valid) begin
            el = 0;
            frame = build_frame(dif.d_in);
         end
      end else begin
         el++;
         if (el == NBits * int'(Cpb)) el = -1;
      end
      #1;
      chk("model_tx", {31'd0, tx}, {31'd0, (el < 0) ? 1'b1 : frame[el / int'(Cpb)]});
      chk("model_busy", {31'd0, busy}, {31'd0, el >= 0});
      chk("model_ready", {31'd0, dif.d_ready}, {31'd0, el < 0});
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, {31'd0, busy}, 32'd0);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      dif.d_valid = 1'b1;
      dif.d_in    = b;
      @(posedge clk);
      #1;
      chk("send_accept", {31'd0, busy}, 32'd1);
      @(negedge clk);
      dif.d_valid = 1'b0;
   endtask

   initial begin
      logic [10:0] lit;
      dif.d_valid = 1'b1;
      dif.d_in    = 8'hA5;

      // Reset with d_valid held: no frame may start.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, dif.d_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      dif.d_valid = 1'b0;

      // 0xA5 pinned bit-by-bit: start, 1,0,1,0,0,1,0,1, [parity 0], stop.
`ifdef UART_TX_PARITY_EN
      lit = 11'b10_1010_0101_0;
`else
      lit = 11'b11_1010_0101_0;
`endif
      @(negedge clk);
      dif.d_valid = 1'b1;
      dif.d_in    = 8'hA5;
      @(posedge clk);
      #1;
      for (int k = 0; k < NBits * int'(Cpb); k++) begin
         chk("a5_tx", {31'd0, tx}, {31'd0, lit[k / int'(Cpb)]});
         chk("a5_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
         dif.d_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("a5_end_busy", {31'd0, busy}, 32'd0);
      chk("a5_end_ready", {31'd0, dif.d_ready}, 32'd1);
      chk("a5_end_tx", {31'd0, tx}, 32'd1);

      // Back-to-back with d_valid held: exactly one idle cycle between frames.
      @(negedge clk);
      dif.d_valid = 1'b1;
      dif.d_in    = 8'h00;
      @(posedge clk);
      #1;
      @(negedge clk);
      dif.d_in = 8'hFF;
      wait_idle("b2b_first_end");
      @(posedge clk);
      #1;
      chk("b2b_gap_busy", {31'd0, busy}, 32'd1);
      chk("b2b_gap_tx", {31'd0, tx}, 32'd0);
      @(negedge clk);
      dif.d_valid = 1'b0;
      wait_idle("b2b_second_end");

      // d_valid pulse mid-frame must be ignored.
      send(8'h81);
      repeat (10) @(negedge clk);
      dif.d_valid = 1'b1;
      dif.d_in    = 8'h3C;
      #1;
      chk("ign_ready", {31'd0, dif.d_ready}, 32'd0);
      @(negedge clk);
      dif.d_valid = 1'b0;
      wait_idle("ign_end");
      repeat (3) @(posedge clk);
      #1;
      chk("ign_no_frame", {31'd0, busy}, 32'd0);

      // Abort 0x55 at cycle 15, then a clean 0x0F frame.
      send(8'h55);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send(8'h0F);
      wait_idle("post_abort_end");

      // Random traffic with occasional resets; the model checks every cycle.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         dif.d_valid = ($urandom_range(0, 3) == 0);
         dif.d_in    = 8'($urandom);
         reset       = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      dif.d_valid = 1'b0;
      wait_idle("rand_end");
      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
